// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter and related blocks.
//   uart_arb_state_t : arbiter FSM states
//   UART_DATA_W      : width of one UART payload byte
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,  // no holder, looking for a requester
        ISSUE      = 2'd1,  // holder granted, waiting to hand a byte to the UART
        WAIT_START = 2'd2,  // byte handed over, waiting for the UART to go busy
        WAIT_DONE  = 2'd3   // UART shifting the frame out
    } uart_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first set bit of req at or
// after index ptr, scanning upward and wrapping at N.
//   req : request vector, one bit per requester
//   ptr : index with highest priority this round (must be < N)
//   idx : chosen index (0 when no request is set)
//   any : at least one request is set
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop, so no path
        // through this block leaves a value unassigned and no latch is built.
        idx = '0;
        any = |req;
        k   = 0;
        // Walk from the farthest candidate to the nearest; the nearest hit is
        // written last and therefore wins.
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters. A grant
// is held for a whole packet (until a byte flagged last has been sent), so
// packets never interleave. Grants rotate round-robin. A holder that stalls
// for LOCK_TIMEOUT cycles with no byte loses its grant.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_req_valid/data/last, o_req_ready : per-requester byte handshake
//   o_tx_en, o_tx_data, i_tx_busy      : UART transmitter start interface
//   o_grant_valid, o_grant_id          : current holder
//   o_timeout                          : one-cycle pulse on a revoked grant
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_tx_en,
    output logic [UART_DATA_W-1:0]         o_tx_data,
    input  logic                           i_tx_busy,
    output logic                           o_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    uart_arb_state_t  state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic             last_q, last_nxt;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [IDX_W-1:0]       grant_inc;
    logic                   cur_valid;
    logic                   cur_last;
    logic [UART_DATA_W-1:0] cur_data;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req (i_req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Priority moves to the requester just after the one released.
    assign grant_inc = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

    assign cur_valid = i_req_valid[grant];
    assign cur_last  = i_req_last[grant];
    assign cur_data  = i_req_data[UART_DATA_W*grant +: UART_DATA_W];

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        stall_cnt_nxt = stall_cnt;
        last_nxt      = last_q;
        o_tx_en       = 1'b0;
        o_req_ready   = '0;
        o_tx_data     = '0;
        o_timeout     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt     = pick_idx;
                    stall_cnt_nxt = '0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (stall_cnt == CNT_W'(LOCK_TIMEOUT)) begin
                    o_timeout     = 1'b1;
                    rr_ptr_nxt    = grant_inc;
                    stall_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end else if (cur_valid && !i_tx_busy) begin
                    // Busy gating also covers a frame left running by a reset.
                    o_tx_en            = 1'b1;
                    o_req_ready[grant] = 1'b1;
                    o_tx_data          = cur_data;
                    last_nxt           = cur_last;
                    stall_cnt_nxt      = '0;
                    state_nxt          = WAIT_START;
                end else if (!cur_valid) begin
                    // Only a holder with nothing to send counts as stalled.
                    stall_cnt_nxt = stall_cnt + CNT_W'(1);
                end
            end
            WAIT_START: begin
                if (i_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        rr_ptr_nxt = grant_inc;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt  = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Nothing may transfer during a reset cycle, whatever the state.
        if (i_rst) begin
            o_tx_en     = 1'b0;
            o_req_ready = '0;
            o_tx_data   = '0;
            o_timeout   = 1'b0;
        end
    end

    assign o_grant_valid = !i_rst && (state != IDLE);
    assign o_grant_id    = o_grant_valid ? grant : '0;

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            stall_cnt <= stall_cnt_nxt;
            last_q    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with NUM_REQ=4, LOCK_TIMEOUT=16 and a
// UART busy model that rises one cycle after o_tx_en and stays high 12 cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int IDX_W        = 2;
    localparam int LOCK_TIMEOUT = 16;
    localparam int BUSY_CYC     = 12;
    localparam int MAX_B        = 8;
    localparam int MAX_LOG      = 32;

    logic                   i_clk       = 1'b0;
    logic                   i_rst       = 1'b1;
    logic [NUM_REQ-1:0]     i_req_valid = '0;
    logic [8*NUM_REQ-1:0]   i_req_data  = '0;
    logic [NUM_REQ-1:0]     i_req_last  = '0;
    logic [NUM_REQ-1:0]     o_req_ready;
    logic                   o_tx_en;
    logic [7:0]             o_tx_data;
    logic                   i_tx_busy;
    logic                   o_grant_valid;
    logic [IDX_W-1:0]       o_grant_id;
    logic                   o_timeout;

    logic [3:0] busy_cnt = '0;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int proto_err = 0;

    // Per-requester byte sources.
    logic [7:0] src_data [NUM_REQ][MAX_B];
    logic       src_last [NUM_REQ][MAX_B];
    int         src_len  [NUM_REQ];
    int         src_pos  [NUM_REQ];

    // Log of UART starts and timeout pulses.
    logic [7:0]       log_data [MAX_LOG];
    logic [IDX_W-1:0] log_id   [MAX_LOG];
    int               log_cyc  [MAX_LOG];
    int               n_log = 0;
    int               to_cyc = 0;
    logic [IDX_W-1:0] to_id = '0;
    int               n_to = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ready   (o_req_ready),
        .o_tx_en       (o_tx_en),
        .o_tx_data     (o_tx_data),
        .i_tx_busy     (i_tx_busy),
        .o_grant_valid (o_grant_valid),
        .o_grant_id    (o_grant_id),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // UART busy model: independent of reset, so a started frame completes.
    always @(posedge i_clk) begin
        if (o_tx_en) busy_cnt <= 4'(BUSY_CYC);
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign i_tx_busy = (busy_cnt != 4'd0);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src_pos[k] < src_len[k]) begin
                i_req_valid[k]       = 1'b1;
                i_req_data[8*k +: 8] = src_data[k][src_pos[k]];
                i_req_last[k]        = src_last[k][src_pos[k]];
            end else begin
                i_req_valid[k]       = 1'b0;
                i_req_data[8*k +: 8] = 8'h00;
                i_req_last[k]        = 1'b0;
            end
        end
    endtask

    task automatic load_byte(input int k, input logic [7:0] d, input logic last);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = last;
        src_len[k]++;
        drive_inputs();
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NUM_REQ; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive_inputs();
    endtask

    task automatic clear_log();
        n_log = 0;
        n_to  = 0;
    endtask

    function automatic bit all_drained();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src_pos[k] < src_len[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: sample outputs at the falling edge, update sources after the
    // rising edge according to the handshakes that edge accepted.
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        @(negedge i_clk);
        cyc++;
        hs = o_req_ready & i_req_valid;
        if (o_tx_en && i_tx_busy) proto_err++;
        if ($countones(o_req_ready) > 1) proto_err++;
        if ((o_req_ready != '0) != o_tx_en) proto_err++;
        if (o_tx_en && (o_req_ready != NUM_REQ'(1) << o_grant_id)) proto_err++;
        if (o_tx_en && !o_grant_valid) proto_err++;
        if (!o_grant_valid && (o_grant_id != '0)) proto_err++;
        if (o_tx_en && (n_log < MAX_LOG)) begin
            log_data[n_log] = o_tx_data;
            log_id[n_log]   = o_grant_id;
            log_cyc[n_log]  = cyc;
            n_log++;
        end
        if (o_timeout) begin
            to_cyc = cyc;
            to_id  = o_grant_id;
            n_to++;
        end
        @(posedge i_clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hs[k]) src_pos[k]++;
        end
        drive_inputs();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = all_drained() && !o_grant_valid && !i_tx_busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: not idle after %0d cycles (sent %0d bytes)", name, budget, n_log);
        end
    endtask

    task automatic run_until_tx(input int n, input int budget, input string name);
        for (int i = 0; i < budget && n_log < n; i++) step();
        checks++;
        if (n_log < n) begin
            errors++;
            $display("FAIL %s_tx_wait: saw %0d starts, required %0d", name, n_log, n);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_srcs();
        step();
        step();
        i_rst = 1'b0;
        for (int i = 0; i < 20 && i_tx_busy; i++) step();
        clear_log();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        clear_srcs();
        load_byte(0, 8'h99, 1'b1);
        step();
        step();
        step();
        checks++;
        if (n_log !== 0) begin errors++; $display("FAIL reset_no_tx: starts=%0d required 0", n_log); end
        checks++;
        if (o_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", o_tx_en); end
        checks++;
        if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
        checks++;
        if (o_grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", o_grant_valid); end
        checks++;
        if (o_grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", o_grant_id); end
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
        checks++;
        if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data); end
        clear_srcs();
        i_rst = 1'b0;
        step();
        step();
        checks++;
        if (o_grant_valid !== 1'b0) begin errors++; $display("FAIL idle_grant_valid: got %b want 0", o_grant_valid); end
        clear_log();
    endtask

    task automatic test_single_packet();
        do_reset();
        load_byte(0, 8'h55, 1'b0);
        load_byte(0, 8'hA3, 1'b1);
        run_until_idle(100, "single");
        checks++;
        if (n_log !== 2) begin errors++; $display("FAIL single_count: got %0d starts want 2", n_log); end
        checks++;
        if (log_data[0] !== 8'h55) begin errors++; $display("FAIL single_byte0: got %h want 55", log_data[0]); end
        checks++;
        if (log_data[1] !== 8'hA3) begin errors++; $display("FAIL single_byte1: got %h want a3", log_data[1]); end
        checks++;
        if (log_id[0] !== 2'd0 || log_id[1] !== 2'd0) begin
            errors++; $display("FAIL single_id: got %0d,%0d want 0,0", log_id[0], log_id[1]);
        end
        // tx at t, busy t+1..t+12, back to ISSUE at t+14.
        checks++;
        if (log_cyc[1] - log_cyc[0] !== 14) begin
            errors++; $display("FAIL single_spacing: got %0d cycles want 14", log_cyc[1] - log_cyc[0]);
        end
        // Pointer moved to 1, so requester 1 beats requester 0.
        clear_log();
        load_byte(0, 8'hB0, 1'b1);
        load_byte(1, 8'hB1, 1'b1);
        run_until_idle(100, "rr_ptr");
        checks++;
        if (n_log !== 2 || log_id[0] !== 2'd1 || log_id[1] !== 2'd0) begin
            errors++; $display("FAIL rr_ptr_order: got n=%0d ids %0d,%0d want 2 ids 1,0", n_log, log_id[0], log_id[1]);
        end
    endtask

    task automatic test_contention();
        logic [7:0]       exp_d [4];
        logic [IDX_W-1:0] exp_i [4];
        exp_d = '{8'h11, 8'h12, 8'h21, 8'h22};
        exp_i = '{2'd1, 2'd1, 2'd2, 2'd2};
        do_reset();
        load_byte(1, 8'h11, 1'b0);
        load_byte(1, 8'h12, 1'b1);
        load_byte(2, 8'h21, 1'b0);
        load_byte(2, 8'h22, 1'b1);
        run_until_idle(200, "contention");
        checks++;
        if (n_log !== 4) begin errors++; $display("FAIL contention_count: got %0d want 4", n_log); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_id[i] !== exp_i[i] || log_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL contention_seq[%0d]: got id %0d data %h want id %0d data %h",
                         i, log_id[i], log_data[i], exp_i[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < 2; j++) load_byte(k, 8'(16 * k + j + 1), 1'b1);
        end
        run_until_idle(400, "fairness");
        checks++;
        if (n_log !== 8) begin errors++; $display("FAIL fairness_count: got %0d want 8", n_log); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_id[i] !== IDX_W'(i % 4) || log_data[i] !== 8'(16 * (i % 4) + (i / 4) + 1)) begin
                errors++;
                $display("FAIL fairness_seq[%0d]: got id %0d data %h want id %0d data %h",
                         i, log_id[i], log_data[i], i % 4, 8'(16 * (i % 4) + (i / 4) + 1));
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_byte(3, 8'h3C, 1'b0);
        run_until_tx(1, 50, "timeout");
        // Requester 0 becomes valid while 3 holds the grant and stalls.
        load_byte(0, 8'h0F, 1'b1);
        run_until_idle(200, "timeout");
        checks++;
        if (n_to !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", n_to); end
        // tx at t, ISSUE re-entered at t+14, 16 stalled cycles later -> t+30.
        checks++;
        if (to_cyc - log_cyc[0] !== 30) begin
            errors++; $display("FAIL timeout_time: got %0d cycles after tx want 30", to_cyc - log_cyc[0]);
        end
        checks++;
        if (to_id !== 2'd3) begin errors++; $display("FAIL timeout_holder: got %0d want 3", to_id); end
        checks++;
        if (n_log !== 2 || log_data[0] !== 8'h3C) begin
            errors++; $display("FAIL timeout_starts: got n=%0d first %h want 2 first 3c", n_log, log_data[0]);
        end
        checks++;
        if (log_id[1] !== 2'd0 || log_data[1] !== 8'h0F) begin
            errors++; $display("FAIL timeout_next: got id %0d data %h want id 0 data 0f", log_id[1], log_data[1]);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load_byte(0, 8'h01, 1'b0);
        load_byte(0, 8'h02, 1'b0);
        load_byte(0, 8'h03, 1'b1);
        run_until_tx(1, 50, "reset_mid");
        for (int i = 0; i < 4; i++) step();
        // Now in WAIT_DONE with the UART busy.
        i_rst = 1'b1;
        #2;
        checks++;
        if ({o_tx_en, o_req_ready, o_grant_valid, o_grant_id, o_timeout, o_tx_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got en=%b rdy=%b gv=%b id=%0d to=%b data=%h want all 0",
                     o_tx_en, o_req_ready, o_grant_valid, o_grant_id, o_timeout, o_tx_data);
        end
        clear_srcs();
        step();
        i_rst = 1'b0;
        checks++;
        if (o_grant_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got %b want 0", o_grant_valid); end
        load_byte(1, 8'h77, 1'b1);
        run_until_idle(100, "reset_mid");
        // Frame from t ends with busy low at t+13; first legal start there.
        checks++;
        if (n_log !== 2 || log_cyc[1] - log_cyc[0] !== 13) begin
            errors++; $display("FAIL reset_mid_restart: got n=%0d spacing %0d want 2 and 13", n_log, log_cyc[1] - log_cyc[0]);
        end
        checks++;
        if (log_id[1] !== 2'd1 || log_data[1] !== 8'h77) begin
            errors++; $display("FAIL reset_mid_byte: got id %0d data %h want id 1 data 77", log_id[1], log_data[1]);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin
            errors++; $display("FAIL protocol: %0d cycles broke tx_en/busy, ready or grant_id rules, want 0", proto_err);
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        test_reset();
        test_single_packet();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid_packet();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
